// File: rtl/axis_if.sv
// Generic AXI-Stream bundle shared by the command builder and the serializer.
// Master drives payload and valid; slave answers with ready.
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_i2c_cmd_builder.sv
// Expands byte-wide I2C command packets (header, then data bytes) into
// {data, header} words and buffers them for the I2C serializer.
module axis_i2c_cmd_builder #(
    parameter int I2C_ADDR_WIDTH  = 7,
    parameter int I2C_DATA_WIDTH  = 8,
    parameter int AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          arstn,
    axis_if.slave                         s_axis,
    axis_if.master                        m_axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          pkt_active
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // The R/W flag sits just above the address, so it must fit in the byte.
    if (I2C_ADDR_WIDTH >= I2C_DATA_WIDTH) begin : g_bad_addr_width
        $error("I2C_ADDR_WIDTH leaves no room for the R/W bit");
    end

    typedef enum logic {
        ST_HDR,
        ST_DATA
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [I2C_DATA_WIDTH-1:0]  hdr_reg;
    logic [AXIS_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [AXIS_DATA_WIDTH-1:0] wr_data;
    logic                       s_hs;
    logic                       wr_en;
    logic                       rd_en;

    assign s_axis.tready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign m_axis.tvalid = (fifo_count != '0);
    assign m_axis.tdata  = mem[rd_ptr];
    assign m_axis.tlast  = 1'b0;
    assign pkt_active    = (state == ST_DATA);

    assign s_hs  = s_axis.tvalid & s_axis.tready;
    assign wr_en = s_hs & ((state == ST_DATA) | s_axis.tlast);
    assign rd_en = m_axis.tvalid & m_axis.tready;

    // Header-only packets still produce a word, with a zero data byte.
    assign wr_data = (state == ST_DATA) ? {s_axis.tdata, hdr_reg}
                                        : {{I2C_DATA_WIDTH{1'b0}}, s_axis.tdata};

    always_comb begin
        state_next = state;
        case (state)
            ST_HDR:  if (s_hs && !s_axis.tlast) state_next = ST_DATA;
            ST_DATA: if (s_hs && s_axis.tlast)  state_next = ST_HDR;
            default: state_next = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= ST_HDR;
            hdr_reg    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_next;
            if (s_hs && state == ST_HDR) hdr_reg <= s_axis.tdata;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_axis_i2c_cmd_builder.sv
// Scoreboard bench for axis_i2c_cmd_builder: expected words are queued as
// bytes are accepted and compared as the FIFO emits them.
module tb_axis_i2c_cmd_builder;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [2:0] fifo_count;
    logic       pkt_active;

    axis_if #(.DATA_WIDTH(8))  s_if ();
    axis_if #(.DATA_WIDTH(16)) m_if ();

    axis_i2c_cmd_builder dut (
        .clk        (clk),
        .arstn      (arstn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .fifo_count (fifo_count),
        .pkt_active (pkt_active)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q [$];
    logic [7:0]  pkt_data [16];
    int          n_checks = 0;
    int          n_fail = 0;
    int          act_cycles = 0;
    int          max_count = 0;

    always @(negedge clk) begin
        if (pkt_active) act_cycles++;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end

    // Output handshake happens at the next posedge; pop and compare now.
    always @(negedge clk) begin
        logic [15:0] exp;
        if (arstn && m_if.tvalid && m_if.tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL out_word: got unexpected word %h, queue empty", m_if.tdata);
            end else begin
                exp = exp_q.pop_front();
                if (m_if.tdata !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL out_word: got %h expected %h", m_if.tdata, exp);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last,
                             input logic do_push, input logic [15:0] exp);
        int waited = 0;
        @(posedge clk); #1;
        s_if.tdata  = b;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_if.tready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL in_timeout: tready got %b expected 1 for byte %h", s_if.tready, b);
        end else if (do_push) begin
            exp_q.push_back(exp);
        end
    endtask

    task automatic s_idle();
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n);
        if (n == 0) begin
            send_byte(hdr, 1'b1, 1'b1, {8'h00, hdr});
        end else begin
            send_byte(hdr, 1'b0, 1'b0, 16'h0);
            for (int i = 0; i < n; i++)
                send_byte(pkt_data[i], (i == n - 1), 1'b1, {pkt_data[i], hdr});
        end
        s_idle();
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0 || m_if.tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d words pending tvalid=%b expected 0 and 0",
                     exp_q.size(), m_if.tvalid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0 || fifo_count !== 3'd0 || pkt_active !== 1'b0 || s_if.tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got tvalid=%b count=%0d active=%b tready=%b expected 0 0 0 1",
                     m_if.tvalid, fifo_count, pkt_active, s_if.tready);
        end
        #20 arstn = 1'b1;
    endtask

    task automatic test_basic();
        m_if.tready = 1'b1;
        act_cycles  = 0;
        send_byte(8'h50, 1'b0, 1'b0, 16'h0);
        send_byte(8'hA5, 1'b1, 1'b1, 16'hA550);
        s_idle();
        @(negedge clk);
        n_checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'hA550) begin
            n_fail++;
            $display("[TB] FAIL basic_latency: got tvalid=%b tdata=%h expected 1 a550", m_if.tvalid, m_if.tdata);
        end
        wait_drain();
        n_checks++;
        if (act_cycles != 1) begin
            n_fail++;
            $display("[TB] FAIL basic_active: got %0d cycles expected 1", act_cycles);
        end
    endtask

    task automatic test_multi();
        pkt_data[0] = 8'h01; pkt_data[1] = 8'h02; pkt_data[2] = 8'h03;
        send_pkt(8'hD0, 3);
        wait_drain();
        n_checks++;
        if (pkt_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL multi_state: got pkt_active=%b expected 0", pkt_active);
        end
    endtask

    task automatic test_hdr_only();
        act_cycles = 0;
        send_pkt(8'h3C, 0);
        wait_drain();
        n_checks++;
        if (act_cycles != 0) begin
            n_fail++;
            $display("[TB] FAIL hdr_only_active: got %0d cycles expected 0", act_cycles);
        end
    endtask

    task automatic test_full();
        m_if.tready = 1'b0;
        max_count   = 0;
        for (int i = 0; i < 6; i++) pkt_data[i] = 8'hB0 + 8'(i);
        fork
            send_pkt(8'h10, 6);
            begin
                int w = 0;
                while (fifo_count != 3'd4 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                repeat (3) @(negedge clk);
                n_checks++;
                if (fifo_count !== 3'd4 || s_if.tready !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL full_state: got count=%0d tready=%b expected 4 0", fifo_count, s_if.tready);
                end
                @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (max_count > 4) begin
            n_fail++;
            $display("[TB] FAIL full_max: got %0d expected at most 4", max_count);
        end
    endtask

    task automatic test_back_to_back();
        m_if.tready = 1'b0;
        send_byte(8'h77, 1'b0, 1'b0, 16'h0);
        send_byte(8'hC0, 1'b0, 1'b1, 16'hC077);
        send_byte(8'hC1, 1'b0, 1'b1, 16'hC177);
        fork
            for (int i = 0; i < 10; i++)
                send_byte(8'hE0 + 8'(i), (i == 9), 1'b1, {8'hE0 + 8'(i), 8'h77});
            begin
                @(posedge clk); #1;
                m_if.tready = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (fifo_count !== 3'd2) begin
                        n_fail++;
                        $display("[TB] FAIL simul_count: cycle %0d got %0d expected 2", i, fifo_count);
                    end
                end
            end
        join
        s_idle();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        m_if.tready = 1'b0;
        send_byte(8'h22, 1'b0, 1'b0, 16'h0);
        send_byte(8'h33, 1'b0, 1'b1, 16'h3322);
        s_idle();
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd1 || pkt_active !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset: got count=%0d active=%b expected 1 1", fifo_count, pkt_active);
        end
        arstn = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (m_if.tvalid !== 1'b0 || fifo_count !== 3'd0 || pkt_active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got tvalid=%b count=%0d active=%b expected 0 0 0",
                     m_if.tvalid, fifo_count, pkt_active);
        end
        #12 arstn = 1'b1;
        m_if.tready = 1'b1;
        pkt_data[0] = 8'h55;
        send_pkt(8'h44, 1);
        wait_drain();
    endtask

    initial begin
        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        test_reset();
        test_basic();
        test_multi();
        test_hdr_only();
        test_full();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_i2c_cmd_builder.md
# axis_i2c_cmd_builder

- Upstream neighbour of the I2C master/slave serializer.
- Accepts a byte-wide AXI-Stream of I2C command packets: one header byte (address + R/W), then one or more data bytes, with tlast on the final byte.
- Expands each packet into 16-bit words {data, header} and buffers them in a small FIFO.
- Presents the words on a 16-bit AXI-Stream master, which feeds the serializer's `s_axis`.

## Interface
Parameters:
- I2C_ADDR_WIDTH, 7, address bits in the header byte.
- I2C_DATA_WIDTH, 8, byte width on the input stream.
- AXIS_DATA_WIDTH, I2C_DATA_WIDTH*2, output word width.
- FIFO_DEPTH, 4, word entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- arstn  input  1  asynchronous, active-low reset.
- s_axis  axis_if.slave  tdata I2C_DATA_WIDTH, tvalid, tready, tlast  byte command stream.
- m_axis  axis_if.master  tdata AXIS_DATA_WIDTH, tvalid, tready  packed word stream to the serializer.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- pkt_active  output  1  high while in DATA state (header latched, packet open).

## Operation
- Header byte layout: [I2C_ADDR_WIDTH-1:0] address; bit I2C_ADDR_WIDTH is R/W (1 = read).
- Output word: [7:0] = header; [15:8] = data byte.
- State HDR (reset state):
  - On s_axis handshake, latch tdata into hdr_reg.
  - With tlast=0, go to DATA; nothing is written to the FIFO.
  - With tlast=1 (header-only packet), write {8'h00, tdata} and stay in HDR.
- State DATA:
  - Each s_axis handshake writes {tdata, hdr_reg} to the FIFO.
  - With tlast=1, return to HDR.
  - hdr_reg is reused for every byte of the packet.
- s_axis.tready = (fifo_count != FIFO_DEPTH) in both states, combinational from registered count.
  - Headers are gated by the same condition, so packet boundaries never depend on FIFO state.
- FIFO: circular buffer with write and read pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
  - Write enable = s_axis.tvalid & s_axis.tready & (state==DATA | tlast).
  - Read enable = m_axis.tvalid & m_axis.tready.
- fifo_count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous read+write.
  - Simultaneous read+write is legal at any nonzero, non-full count. At count 0 only a write can occur; at FIFO_DEPTH only a read can occur.
- m_axis.tvalid = (fifo_count != 0).
- m_axis.tdata = mem[rd_ptr] while tvalid is high. tdata is stable until the handshake completes.
- pkt_active = (state == DATA).

## Timing
- Reset values: state=HDR, rd_ptr=wr_ptr=0, fifo_count=0, hdr_reg=0, m_axis.tvalid=0, pkt_active=0, s_axis.tready=1.
- Latency: a data byte accepted at edge N is visible on m_axis with tvalid=1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput: one byte per cycle. The header beat costs one input cycle with no output word, except on header-only packets.
- Full: tready drops in the cycle after the write that reaches FIFO_DEPTH. It rises in the cycle after a read.
- Empty: tvalid drops in the cycle after the last read.
- Reset mid-packet: immediately returns to HDR and flushes the FIFO. The next accepted byte is treated as a header.
- tvalid-without-tready upstream or downstream is held indefinitely with no data loss or duplication.
- tlast is ignored except to end a packet; a missing tlast keeps the block in DATA indefinitely.

## Test plan
- Basic packet: send 0x50, 0xA5(tlast) → after reset, one word 0xA550 appears on m_axis one cycle after the 0xA5 handshake; pkt_active high for exactly one cycle.
- Multi-byte packet: send 0xD0, 0x01, 0x02, 0x03(tlast) with m_axis.tready=1 → words 0x01D0, 0x02D0, 0x03D0 in order; state returns to HDR.
- Header-only packet: send 0x3C(tlast) → single word 0x003C; pkt_active stays 0.
- Backpressure/full: hold m_axis.tready=0 and stream 0x10, then 6 data bytes → tready falls after 4 words and fifo_count=4. Then release tready → all 6 words emerge in order with header 0x10, and the count never exceeds 4.
- Simultaneous read/write: with count=2, drive both handshakes each cycle for 10 cycles → fifo_count stays 2; pointer wrap gives correct ordering.
- Reset mid-packet: assert arstn low after header 0x22 and one data byte, while the FIFO holds 1 word → m_axis.tvalid=0 and fifo_count=0 immediately. After release, sending 0x44, 0x55(tlast) yields 0x5544.
